// File: rtl/simon_pkg.sv
// ============================================================================
// Module  : simon_pkg
// Brief   : Colour encoding and tone/LED lookup shared by the Simon tone path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package simon_pkg;

   typedef enum logic [1:0] {
      GREEN  = 2'd0,
      RED    = 2'd1,
      YELLOW = 2'd2,
      BLUE   = 2'd3
   } colour_t;

   localparam logic [31:0] FREQ_GREEN  = 32'd415;
   localparam logic [31:0] FREQ_RED    = 32'd310;
   localparam logic [31:0] FREQ_YELLOW = 32'd252;
   localparam logic [31:0] FREQ_BLUE   = 32'd209;
   localparam logic [31:0] ERR_FREQ    = 32'd42;

   function automatic logic [31:0] colour_to_freq(input colour_t c);
      logic [31:0] f;
      case (c)
         GREEN:   f = FREQ_GREEN;
         RED:     f = FREQ_RED;
         YELLOW:  f = FREQ_YELLOW;
         default: f = FREQ_BLUE;
      endcase
      return f;
   endfunction

   function automatic logic [3:0] colour_to_led(input colour_t c);
      return 4'b0001 << c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ms_down_timer.sv
// ============================================================================
// Module  : ms_down_timer
// Brief   : Loadable 32-bit down-counter that stops at zero; zero flag exposed.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ms_down_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_load,
   input  logic [31:0] i_value,
   output logic        o_zero
);

   logic [31:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= 32'd0;
      end else if (i_load) begin
         r_count <= i_value;
      end else if (r_count != 32'd0) begin
         r_count <= r_count - 32'd1;
      end
   end

   assign o_zero = (r_count == 32'd0);

endmodule

`default_nettype wire

// File: rtl/tone_sequencer.sv
// ============================================================================
// Module  : tone_sequencer
// Brief   : Plays a stored Simon pattern or the error tone, echoes buttons idle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_sequencer
   import simon_pkg::*;
#(
   parameter int FCLK    = 50_000_000,
   parameter int MAX_LEN = 32,
   parameter int TONE_MS = 400,
   parameter int GAP_MS  = 100,
   parameter int ERR_MS  = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        err_req,
   input  logic [5:0]  seq_len,
   output logic [5:0]  seq_addr,
   input  logic [1:0]  seq_colour,
   input  logic [3:0]  btn,
   output logic [31:0] freq,
   output logic [3:0]  led,
   output logic        busy,
   output logic        done
);

   localparam int          CYC_PER_MS = FCLK / 1000;
   localparam logic [31:0] c_tone_cyc = 32'(TONE_MS * CYC_PER_MS - 1);
   localparam logic [31:0] c_gap_cyc  = 32'(GAP_MS * CYC_PER_MS - 1);
   localparam logic [31:0] c_err_cyc  = 32'(ERR_MS * CYC_PER_MS - 1);
   localparam logic [6:0]  c_max_len  = 7'(MAX_LEN);

   if (TONE_MS <= 0 || GAP_MS <= 0 || ERR_MS <= 0 || CYC_PER_MS <= 0) begin : g_bad_duration
      $error("tone_sequencer: every duration must be at least 1 ms and 1 cycle");
   end
   if (MAX_LEN < 1 || MAX_LEN > 64 || (MAX_LEN & (MAX_LEN - 1)) != 0) begin : g_bad_max_len
      $error("tone_sequencer: MAX_LEN must be a power of two no larger than 64");
   end

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      TONE   = 3'd2,
      GAP    = 3'd3,
      ERR    = 3'd4,
      FINISH = 3'd5
   } state_t;

   state_t      r_state, w_state;
   logic [5:0]  r_len, w_len;
   logic [5:0]  r_idx, w_idx;
   logic [5:0]  r_addr, w_addr;
   logic [31:0] r_freq, w_freq;
   logic [3:0]  r_led, w_led;
   logic        r_busy, w_busy;
   logic        r_done, w_done;

   logic        w_tmr_load;
   logic [31:0] w_tmr_value;
   logic        w_tmr_zero;

   logic        w_btn_onehot;
   colour_t     w_btn_colour;
   logic        w_len_ok;

   ms_down_timer u_timer (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_tmr_load),
      .i_value (w_tmr_value),
      .o_zero  (w_tmr_zero)
   );

   assign w_btn_onehot = (btn != 4'd0) && ((btn & (btn - 4'd1)) == 4'd0);
   assign w_len_ok     = (seq_len != 6'd0) && ({1'b0, seq_len} <= c_max_len);

   always_comb begin
      case (btn)
         4'b0010: w_btn_colour = RED;
         4'b0100: w_btn_colour = YELLOW;
         4'b1000: w_btn_colour = BLUE;
         default: w_btn_colour = GREEN;
      endcase
   end

   always_comb begin
      w_state     = r_state;
      w_len       = r_len;
      w_idx       = r_idx;
      w_addr      = r_addr;
      w_freq      = r_freq;
      w_led       = r_led;
      w_busy      = r_busy;
      w_done      = 1'b0;
      w_tmr_load  = 1'b0;
      w_tmr_value = 32'd0;

      case (r_state)
         IDLE: begin
            if (err_req) begin
               w_freq      = ERR_FREQ;
               w_led       = 4'b1111;
               w_busy      = 1'b1;
               w_tmr_load  = 1'b1;
               w_tmr_value = c_err_cyc;
               w_state     = ERR;
            end else if (start) begin
               w_freq = 32'd0;
               w_led  = 4'd0;
               if (w_len_ok) begin
                  w_len   = seq_len;
                  w_idx   = 6'd0;
                  w_addr  = 6'd0;
                  w_busy  = 1'b1;
                  w_state = LOAD;
               end else begin
                  // Bad length: acknowledge with a bare done pulse, no tone.
                  w_busy  = 1'b0;
                  w_done  = 1'b1;
                  w_state = FINISH;
               end
            end else if (w_btn_onehot) begin
               w_freq = colour_to_freq(w_btn_colour);
               w_led  = btn;
            end else begin
               w_freq = 32'd0;
               w_led  = 4'd0;
            end
         end

         LOAD: begin
            // seq_addr already points at r_idx, so seq_colour is valid now.
            w_freq      = colour_to_freq(colour_t'(seq_colour));
            w_led       = colour_to_led(colour_t'(seq_colour));
            w_tmr_load  = 1'b1;
            w_tmr_value = c_tone_cyc;
            w_state     = TONE;
         end

         TONE: begin
            if (w_tmr_zero) begin
               w_freq      = 32'd0;
               w_led       = 4'd0;
               w_tmr_load  = 1'b1;
               w_tmr_value = c_gap_cyc;
               w_state     = GAP;
            end
         end

         GAP: begin
            if (w_tmr_zero) begin
               if (r_idx == 6'(r_len - 6'd1)) begin
                  w_busy  = 1'b0;
                  w_done  = 1'b1;
                  w_state = FINISH;
               end else begin
                  w_idx   = r_idx + 6'd1;
                  w_addr  = r_idx + 6'd1;
                  w_state = LOAD;
               end
            end
         end

         ERR: begin
            if (w_tmr_zero) begin
               w_freq  = 32'd0;
               w_led   = 4'd0;
               w_busy  = 1'b0;
               w_done  = 1'b1;
               w_state = FINISH;
            end
         end

         FINISH: begin
            w_busy  = 1'b0;
            w_state = IDLE;
         end

         default: begin
            w_freq  = 32'd0;
            w_led   = 4'd0;
            w_busy  = 1'b0;
            w_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_len   <= 6'd0;
         r_idx   <= 6'd0;
         r_addr  <= 6'd0;
         r_freq  <= 32'd0;
         r_led   <= 4'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_len   <= w_len;
         r_idx   <= w_idx;
         r_addr  <= w_addr;
         r_freq  <= w_freq;
         r_led   <= w_led;
         r_busy  <= w_busy;
         r_done  <= w_done;
      end
   end

   assign seq_addr = r_addr;
   assign freq     = r_freq;
   assign led      = r_led;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_tone_sequencer.sv
// ============================================================================
// Module  : tb_tone_sequencer
// Brief   : Directed self-checking bench for tone_sequencer with 1 ms = 1 cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tone_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        err_req;
   logic [5:0]  seq_len;
   logic [5:0]  seq_addr;
   logic [1:0]  seq_colour;
   logic [3:0]  btn;
   logic [31:0] freq;
   logic [3:0]  led;
   logic        busy;
   logic        done;

   logic [1:0]  mem [0:63];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   assign seq_colour = mem[seq_addr];

   tone_sequencer #(
      .FCLK    (1000),
      .MAX_LEN (8),
      .TONE_MS (4),
      .GAP_MS  (2),
      .ERR_MS  (6)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .err_req    (err_req),
      .seq_len    (seq_len),
      .seq_addr   (seq_addr),
      .seq_colour (seq_colour),
      .btn        (btn),
      .freq       (freq),
      .led        (led),
      .busy       (busy),
      .done       (done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, ".freq"}, freq, 32'd0);
      check({tag, ".led"},  {28'd0, led}, 32'd0);
      check({tag, ".busy"}, {31'd0, busy}, 32'd0);
      check({tag, ".done"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      logic [31:0] ef [3];
      logic [3:0]  el [3];
      logic [5:0]  bad_len [2];
      int          ndone;

      ef = '{32'd310, 32'd209, 32'd415};
      el = '{4'b0010, 4'b1000, 4'b0001};
      bad_len = '{6'd0, 6'd9};
      for (int i = 0; i < 64; i++) mem[i] = 2'd0;
      mem[0] = 2'd1;   // RED
      mem[1] = 2'd3;   // BLUE
      mem[2] = 2'd0;   // GREEN

      reset = 1'b1; start = 1'b0; err_req = 1'b0; seq_len = 6'd0; btn = 4'd0;
      @(negedge clk);
      tick();
      check_idle_outputs("reset");
      check("reset.addr", {26'd0, seq_addr}, 32'd0);
      reset = 1'b0;
      tick();
      tick();
      check_idle_outputs("idle");

      // Button echo
      btn = 4'b0100;
      tick();
      check("echo.freq", freq, 32'd252);
      check("echo.led", {28'd0, led}, 32'd4);
      btn = 4'b0110;
      tick();
      check("echo2.freq", freq, 32'd0);
      check("echo2.led", {28'd0, led}, 32'd0);
      btn = 4'd0;
      tick();

      // Three-element pattern with a stray start in a gap and a button press
      start = 1'b1; seq_len = 6'd3;
      tick();
      start = 1'b0;
      ndone = 0;
      for (int k = 1; k <= 23; k++) begin
         int e, p;
         e = (k - 1) / 7;
         p = (k - 1) % 7;
         if (done) ndone++;
         if (k <= 21) begin
            check($sformatf("seq.freq[%0d]", k), freq, (p >= 1 && p <= 4) ? ef[e] : 32'd0);
            check($sformatf("seq.led[%0d]", k), {28'd0, led},
                  (p >= 1 && p <= 4) ? {28'd0, el[e]} : 32'd0);
            check($sformatf("seq.addr[%0d]", k), {26'd0, seq_addr}, 32'(e));
            check($sformatf("seq.busy[%0d]", k), {31'd0, busy}, 32'd1);
            check($sformatf("seq.done[%0d]", k), {31'd0, done}, 32'd0);
         end else begin
            check($sformatf("seq.freq[%0d]", k), freq, 32'd0);
            check($sformatf("seq.addr[%0d]", k), {26'd0, seq_addr}, 32'd2);
            check($sformatf("seq.busy[%0d]", k), {31'd0, busy}, 32'd0);
            check($sformatf("seq.done[%0d]", k), {31'd0, done}, (k == 22) ? 32'd1 : 32'd0);
         end
         start = (k == 6);
         if (k == 10) btn = 4'b0001;
         if (k == 13) btn = 4'd0;
         tick();
      end
      start = 1'b0;
      check("seq.ndone", 32'(ndone), 32'd1);

      // Error request wins over a simultaneous start
      err_req = 1'b1; start = 1'b1; seq_len = 6'd3;
      tick();
      err_req = 1'b0; start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         check($sformatf("err.freq[%0d]", k), freq, (k <= 6) ? 32'd42 : 32'd0);
         check($sformatf("err.led[%0d]", k), {28'd0, led}, (k <= 6) ? 32'd15 : 32'd0);
         check($sformatf("err.busy[%0d]", k), {31'd0, busy}, (k <= 6) ? 32'd1 : 32'd0);
         check($sformatf("err.done[%0d]", k), {31'd0, done}, (k == 7) ? 32'd1 : 32'd0);
         check($sformatf("err.addr[%0d]", k), {26'd0, seq_addr}, 32'd2);
         tick();
      end

      // Rejected lengths
      for (int j = 0; j < 2; j++) begin
         start = 1'b1; seq_len = bad_len[j];
         tick();
         start = 1'b0;
         check($sformatf("rej%0d.done1", bad_len[j]), {31'd0, done}, 32'd1);
         check($sformatf("rej%0d.busy1", bad_len[j]), {31'd0, busy}, 32'd0);
         check($sformatf("rej%0d.freq1", bad_len[j]), freq, 32'd0);
         tick();
         check($sformatf("rej%0d.done2", bad_len[j]), {31'd0, done}, 32'd0);
         check($sformatf("rej%0d.busy2", bad_len[j]), {31'd0, busy}, 32'd0);
         tick();
      end

      // Reset in the middle of a tone
      start = 1'b1; seq_len = 6'd3;
      tick();
      start = 1'b0;
      tick();
      check("rst.pre_freq", freq, 32'd310);
      reset = 1'b1;
      tick();
      check_idle_outputs("rst.mid");
      check("rst.addr", {26'd0, seq_addr}, 32'd0);
      reset = 1'b0;
      tick();
      tick();
      check_idle_outputs("rst.after");
      btn = 4'b1000;
      tick();
      check("rst.echo_freq", freq, 32'd209);
      check("rst.echo_led", {28'd0, led}, 32'd8);
      btn = 4'd0;
      tick();
      check("rst.echo_off", freq, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
